// File: rtl/mux_pkg.sv
// Shared constants and helpers for the pipelined word multiplexer (mux_pipe_scan).
package mux_pkg;

    localparam int NCH_MIN = 4;
    localparam int NCH_MAX = 256;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_AUTO   = 1'b1
    } mode_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mux_pipe_scan_mux4_w.sv
// Combinational 4:1 word multiplexer, the building block of both pipeline stages.
module mux4_w
    import mux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [4*WIDTH-1:0] data_i,
    input  logic [1:0]         sel_i,
    output logic [WIDTH-1:0]   data_o
);

    always_comb begin
        data_o = data_i[0 +: WIDTH];
        case (sel_i)
            2'd0: data_o = data_i[0*WIDTH +: WIDTH];
            2'd1: data_o = data_i[1*WIDTH +: WIDTH];
            2'd2: data_o = data_i[2*WIDTH +: WIDTH];
            2'd3: data_o = data_i[3*WIDTH +: WIDTH];
            default: data_o = data_i[0 +: WIDTH];
        endcase
    end

endmodule

// File: rtl/mux_pipe_scan.sv
// Two-stage pipelined NCH:1 word mux with valid/ready handshake and auto-scan.
// Optional per-channel scan mask is enabled by defining MUX_SCAN_MASK_EN.
module mux_pipe_scan
    import mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH   = 16,
    parameter int SEL_W = clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 auto,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_ch,
    output logic [SEL_W-1:0]     scan_ptr
`ifdef MUX_SCAN_MASK_EN
    ,
    input  logic [NCH-1:0]       ch_mask
`endif
);

    localparam int NGRP   = NCH / 4;
    localparam int LVL    = (SEL_W - 1) / 2;
    localparam int HIP_W  = (LVL > 0) ? 2 * LVL : 1;
    localparam int NPAD   = 1 << (2 * LVL);

    // Offset of tree level lvl inside the flat node array; level 0 holds the padded leaves.
    function automatic int nodeOff(input int lvl);
        int off;
        off = 0;
        for (int k = 0; k < lvl; k++) off += NPAD >> (2 * k);
        return off;
    endfunction

    localparam int NNODE = nodeOff(LVL + 1);

    logic                 s1_valid_q, s1_valid_d;
    logic [SEL_W-1:0]     s1_ch_q;
    logic [WIDTH-1:0]     s1_grp_q [NGRP];
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     out_data_q;
    logic [SEL_W-1:0]     out_ch_q;
    logic [SEL_W-1:0]     scan_ptr_q, scan_ptr_d;

    logic [SEL_W:0]       scanHit;
    logic [SEL_W-1:0]     effCh;
    logic                 autoOk;
    logic                 accept;
    logic                 s2Load;
    logic [WIDTH-1:0]     grpMux [NGRP];
    logic [WIDTH-1:0]     treeNode [NNODE];
    logic [WIDTH-1:0]     treeRoot;

`ifdef MUX_SCAN_MASK_EN
    // Cyclic priority search from start inclusive; MSB of the result flags a hit.
    function automatic logic [SEL_W:0] findNext(input logic [NCH-1:0] mask,
                                                input logic [SEL_W-1:0] start);
        logic [SEL_W:0]   res;
        logic [SEL_W-1:0] idx;
        res = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            idx = start + SEL_W'(i);
            if (mask[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign scanHit = findNext(ch_mask, scan_ptr_q);
`else
    assign scanHit = {1'b1, scan_ptr_q};
`endif

    always_comb begin
        effCh    = (auto == MODE_AUTO) ? scanHit[SEL_W-1:0] : sel;
        autoOk   = (auto == MODE_MANUAL) || scanHit[SEL_W];
        s2Load   = s1_valid_q && (!out_valid_q || out_ready);
        in_ready = autoOk && (!s1_valid_q || !out_valid_q || out_ready);
        accept   = in_valid && in_ready;
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        out_valid_d = out_valid_q;
        scan_ptr_d  = scan_ptr_q;
        if (accept)         s1_valid_d = 1'b1;
        else if (s2Load)    s1_valid_d = 1'b0;
        if (s2Load)         out_valid_d = 1'b1;
        else if (out_ready) out_valid_d = 1'b0;
        if (accept && auto == MODE_AUTO) scan_ptr_d = effCh + SEL_W'(1);
    end

    for (genvar g = 0; g < NGRP; g++) begin : gGrp
        mux4_w #(.WIDTH(WIDTH)) uGrp (
            .data_i (in_data[g*4*WIDTH +: 4*WIDTH]),
            .sel_i  (effCh[1:0]),
            .data_o (grpMux[g])
        );
    end

    // Leaves beyond NGRP are tied off so the stage-2 tree is always a full 4-ary tree.
    for (genvar i = 0; i < NPAD; i++) begin : gLeaf
        if (i < NGRP) begin : gUsed
            assign treeNode[i] = s1_grp_q[i];
        end else begin : gPad
            assign treeNode[i] = '0;
        end
    end

    if (LVL > 0) begin : gTree
        logic [HIP_W-1:0] hiPad;
        assign hiPad = HIP_W'(s1_ch_q[SEL_W-1:2]);
        for (genvar k = 1; k <= LVL; k++) begin : gLvl
            for (genvar j = 0; j < (NPAD >> (2 * k)); j++) begin : gNode
                mux4_w #(.WIDTH(WIDTH)) uNode (
                    .data_i ({treeNode[nodeOff(k-1) + 4*j + 3],
                              treeNode[nodeOff(k-1) + 4*j + 2],
                              treeNode[nodeOff(k-1) + 4*j + 1],
                              treeNode[nodeOff(k-1) + 4*j + 0]}),
                    .sel_i  (hiPad[2*(k-1) +: 2]),
                    .data_o (treeNode[nodeOff(k) + j])
                );
            end
        end
    end

    assign treeRoot = treeNode[NNODE-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_ch_q     <= '0;
            s1_grp_q    <= '{default: '0};
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            scan_ptr_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            scan_ptr_q  <= scan_ptr_d;
            if (accept) begin
                s1_grp_q <= grpMux;
                s1_ch_q  <= effCh;
            end
            if (s2Load) begin
                out_data_q <= treeRoot;
                out_ch_q   <= s1_ch_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign scan_ptr  = scan_ptr_q;

endmodule

// File: tb/tb_mux_pipe_scan.sv
// Self-checking bench for mux_pipe_scan; mask tests are included when MUX_SCAN_MASK_EN is defined.
`timescale 1ns/1ps
module tb_mux_pipe_scan;

    localparam int WIDTH = 8;
    localparam int NCH   = 16;
    localparam int SEL_W = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NCH*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]     sel;
    logic                 auto;
    logic                 in_valid;
    logic                 in_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SEL_W-1:0]     out_ch;
    logic [SEL_W-1:0]     scan_ptr;
    logic [NCH-1:0]       ch_mask;

    int nChecks = 0;
    int nFail   = 0;
    bit chkEn   = 0;
    int dutAcc  = 0;

    typedef struct {
        int               ch;
        logic [WIDTH-1:0] data;
        int               vis;
    } item_t;

    item_t            mdlQ[$];
    int               edgeN;
    int               mdlPtr;
    int               depCh[$];
    logic [WIDTH-1:0] depData[$];

    mux_pipe_scan #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .sel       (sel),
        .auto      (auto),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .scan_ptr  (scan_ptr)
`ifdef MUX_SCAN_MASK_EN
        ,
        .ch_mask   (ch_mask)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic a, input logic [SEL_W-1:0] s, input logic ordy);
        in_valid  = v;
        auto      = a;
        sel       = s;
        out_ready = ordy;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic loadRamp();
        for (int c = 0; c < NCH; c++) in_data[c*WIDTH +: WIDTH] = 8'hA0 + 8'(c);
    endtask

    function automatic bit maskBit(input int k);
`ifdef MUX_SCAN_MASK_EN
        return ch_mask[k];
`else
        return 1'b1;
`endif
    endfunction

    // Effective channel from the rules: manual uses sel, auto takes the first enabled channel from the pointer.
    function automatic void mdlChannel(output int c, output bit ok);
        ok = 1'b1;
        c  = int'(sel);
        if (auto) begin
            ok = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                if (!ok && maskBit((mdlPtr + i) % NCH)) begin
                    ok = 1'b1;
                    c  = (mdlPtr + i) % NCH;
                end
            end
        end
    endfunction

    function automatic bit headVis();
        return (mdlQ.size() > 0) && (mdlQ[0].vis <= edgeN);
    endfunction

    // Model: a 2-deep queue; an item shows 2 edges after accept or on the edge its predecessor leaves.
    always @(posedge clk or posedge rst) begin : mdlProc
        int    c;
        bit    ok;
        bit    vis;
        bit    rdy;
        item_t it;
        if (rst) begin
            mdlQ.delete();
            mdlPtr = 0;
            edgeN  = 0;
        end else begin
            mdlChannel(c, ok);
            vis = headVis();
            rdy = ok && (mdlQ.size() < 2 || (vis && out_ready));
            edgeN++;
            if (vis && out_ready) begin
                depCh.push_back(mdlQ[0].ch);
                depData.push_back(mdlQ[0].data);
                void'(mdlQ.pop_front());
                if (mdlQ.size() > 0 && mdlQ[0].vis < edgeN) mdlQ[0].vis = edgeN;
            end
            if (in_valid && rdy) begin
                it.ch   = c;
                it.data = in_data[c*WIDTH +: WIDTH];
                it.vis  = edgeN + 1;
                mdlQ.push_back(it);
                if (auto) mdlPtr = (c + 1) % NCH;
            end
        end
    end

    always @(negedge clk) begin : cmpProc
        bit vis;
        int c;
        bit ok;
        if (in_valid && in_ready && !rst) dutAcc++;
        if (!rst && chkEn) begin
            vis = headVis();
            mdlChannel(c, ok);
            checkOutput("out_valid", out_valid, vis);
            checkOutput("in_ready", in_ready, ok && (mdlQ.size() < 2 || (vis && out_ready)));
            checkOutput("scan_ptr", scan_ptr, mdlPtr);
            if (vis) begin
                checkOutput("out_data", out_data, mdlQ[0].data);
                checkOutput("out_ch", out_ch, mdlQ[0].ch);
            end
        end
    end

    initial begin
        rst = 1'b1;
        ch_mask = '1;
        loadRamp();
        applyStimulus(0, 0, 0, 1);
        #2;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_out_ch", out_ch, 0);
        checkOutput("rst_scan_ptr", scan_ptr, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        tick(2);
        rst   = 1'b0;
        chkEn = 1'b1;

        // Manual select of channel 5 with a single-cycle valid pulse.
        applyStimulus(1, 0, 5, 1);
        tick(1);
        applyStimulus(0, 0, 5, 1);
        checkOutput("man_valid_1clk", out_valid, 0);
        tick(1);
        checkOutput("man_valid_2clk", out_valid, 1);
        checkOutput("man_data", out_data, 8'hA5);
        checkOutput("man_ch", out_ch, 5);
        tick(2);

        // Auto scan for 18 transfers, wrapping 15 -> 0.
        depCh.delete();
        depData.delete();
        applyStimulus(1, 1, 0, 1);
        tick(18);
        applyStimulus(0, 1, 0, 1);
        tick(4);
        checkOutput("auto_count", depCh.size(), 18);
        for (int i = 0; i < 18; i++)
            checkOutput("auto_seq", (i < depCh.size()) ? depCh[i] : -1, i % 16);
        checkOutput("auto_data15", (depData.size() > 15) ? depData[15] : 8'h00, 8'hAF);
        checkOutput("auto_ptr_wrap", scan_ptr, 2);

        // Backpressure: exactly two accepts, then stall with stable output.
        depCh.delete();
        dutAcc = 0;
        applyStimulus(1, 1, 0, 0);
        tick(6);
        checkOutput("bp_accepts", dutAcc, 2);
        checkOutput("bp_in_ready", in_ready, 0);
        checkOutput("bp_out_ch", out_ch, 2);
        checkOutput("bp_out_data", out_data, 8'hA2);
        applyStimulus(0, 1, 0, 1);
        tick(4);
        checkOutput("bp_drain_count", depCh.size(), 2);
        checkOutput("bp_drain_0", (depCh.size() > 0) ? depCh[0] : -1, 2);
        checkOutput("bp_drain_1", (depCh.size() > 1) ? depCh[1] : -1, 3);
        checkOutput("bp_ptr", scan_ptr, 4);

        // Asynchronous reset while output is valid.
        applyStimulus(1, 1, 0, 1);
        tick(3);
        checkOutput("pre_rst_valid", out_valid, 1);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("async_out_valid", out_valid, 0);
        checkOutput("async_out_data", out_data, 0);
        checkOutput("async_out_ch", out_ch, 0);
        checkOutput("async_scan_ptr", scan_ptr, 0);
        @(posedge clk);
        #1;
        applyStimulus(0, 1, 0, 1);
        rst = 1'b0;
        checkOutput("post_rst_in_ready", in_ready, 1);
        tick(1);

        // Mode switch: auto x3, manual sel=9, back to auto continues from held pointer.
        depCh.delete();
        applyStimulus(1, 1, 0, 1);
        tick(3);
        applyStimulus(1, 0, 9, 1);
        tick(1);
        applyStimulus(1, 1, 0, 1);
        tick(1);
        applyStimulus(0, 1, 0, 1);
        tick(4);
        checkOutput("mode_count", depCh.size(), 5);
        for (int i = 0; i < 5; i++) begin
            int exp;
            exp = (i == 3) ? 9 : ((i == 4) ? 3 : i);
            checkOutput("mode_seq", (i < depCh.size()) ? depCh[i] : -1, exp);
        end
        checkOutput("mode_ptr", scan_ptr, 4);

        // Mixed traffic with random data, modes and backpressure.
        for (int c = 0; c < NCH; c++) in_data[c*WIDTH +: WIDTH] = 8'($urandom);
        for (int i = 0; i < 80; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          SEL_W'($urandom_range(0, NCH - 1)), 1'($urandom_range(0, 1)));
            if (i % 16 == 15) in_data[($urandom_range(0, NCH - 1))*WIDTH +: WIDTH] = 8'($urandom);
            tick(1);
        end
        applyStimulus(0, 0, 0, 1);
        tick(4);

`ifdef MUX_SCAN_MASK_EN
        loadRamp();
        doReset();
        depCh.delete();
        ch_mask = 16'h8101;
        applyStimulus(1, 1, 0, 1);
        tick(5);
        applyStimulus(0, 1, 0, 1);
        tick(4);
        checkOutput("mask_count", depCh.size(), 5);
        for (int i = 0; i < 5; i++) begin
            int exp;
            exp = (i % 3 == 0) ? 0 : ((i % 3 == 1) ? 8 : 15);
            checkOutput("mask_seq", (i < depCh.size()) ? depCh[i] : -1, exp);
        end
        ch_mask = '0;
        dutAcc  = 0;
        applyStimulus(1, 1, 0, 1);
        tick(4);
        checkOutput("mask_zero_accepts", dutAcc, 0);
        checkOutput("mask_zero_in_ready", in_ready, 0);
        checkOutput("mask_zero_out_valid", out_valid, 0);
        applyStimulus(0, 1, 0, 1);
        ch_mask = '1;
        tick(2);
`endif

        chkEn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/mux_pipe_scan.md
# mux_pipe_scan

Parametrised, pipelined N:1 word multiplexer with a valid/ready handshake and an optional auto-scan mode that steps through channels on every accepted transfer. It generalises the fixed 16:1 single-bit mux tree to WIDTH-bit channels and NCH inputs, and adds a register between the 4:1 group level and the final level. It sits between multi-channel sources, such as sensor or ADC lanes, and a single downstream consumer that may apply backpressure.

## Interface
- WIDTH, 8, bits per channel (1..64)
- NCH, 16, channel count; power of 2, 4..256
- SEL_W, $clog2(NCH), derived; do not override
- clk  input  1  single clock; all registers on rising edge
- rst  input  1  asynchronous, active-high reset
- in_data  input  NCH*WIDTH  channel c at bits [c*WIDTH +: WIDTH]
- sel  input  SEL_W  channel index, used when auto=0
- auto  input  1  1 = auto-scan, 0 = manual select
- in_valid  input  1  upstream offers a sample of in_data
- in_ready  output  1  block accepts this cycle (combinational)
- out_valid  output  1  out_data/out_ch hold a valid result
- out_ready  input  1  downstream accepts this cycle
- out_data  output  WIDTH  selected channel word
- out_ch  output  SEL_W  index of the channel that produced out_data
- scan_ptr  output  SEL_W  next channel auto-scan will take
- ch_mask  input  NCH  auto-scan enable per channel (only with MUX_SCAN_MASK_EN)

## Operation
- Accept = in_valid && in_ready. Effective channel: c = auto ? scan_ptr : sel, sampled at accept.
- Stage 1 (on accept): register NCH/4 group results (4:1 on sel bits [1:0] of c), the upper bits c[SEL_W-1:2], and the full c. Sets s1_valid.
- Stage 2 (output regs): final NCH/4:1 mux of the stage-1 groups on the upper bits, giving out_data. out_ch = c. Sets out_valid.
- Advance rules: s2 loads when s1_valid && (!out_valid || out_ready). in_ready = !s1_valid || !out_valid || out_ready.
- out_valid drops when out_ready is high and there is no s1 data to move up.
- out_data/out_ch hold stable while out_valid && !out_ready.
- scan_ptr: on accept with auto=1, it moves to (c+1) mod NCH, so NCH-1 wraps to 0. It holds in manual mode and when there is no accept.
- Toggling auto takes effect at the next accept. In-flight data is unaffected.
- Reset (asynchronous, any time, including mid-stall): s1_valid=0, out_valid=0, out_data=0, out_ch=0, scan_ptr=0. All in-flight samples are dropped. in_ready=1 in the first cycle after reset.

## Timing
- Latency: 2 clk from accept to out_valid when there is no backpressure.
- Throughput: 1 transfer/clk sustained with out_ready held high.
- Capacity: 2 entries (s1 + s2). With out_ready=0, the block accepts at most 2 samples, then in_ready=0.
- in_ready depends combinationally on out_ready (one-level path, no loop through in_valid).

## Configuration
- MUX_SCAN_MASK_EN defined: adds the ch_mask port.
  - In auto mode, c = first channel with ch_mask=1, searching cyclically from scan_ptr inclusive. scan_ptr then moves to (c+1) mod NCH.
  - If ch_mask is all zero and auto=1, in_ready=0.
  - Manual mode ignores ch_mask.
- MUX_SCAN_MASK_EN undefined: no ch_mask port. All channels are enabled and behaviour is as described above.

## Structure
- Shared package mux_pkg: the clog2 function, MODE_MANUAL=0 / MODE_AUTO=1 constants, and the legal NCH range constants.
- Sub-module mux4_w (WIDTH parameter, combinational 4:1 word mux on a 2-bit select). It is instantiated NCH/4 times for stage 1 and reused in a tree for stage 2.
- The cyclic priority search for the mask is a function in mux_pipe_scan, not a separate module.

## Test plan
- NCH=16, WIDTH=8, channel c = 8'hA0+c, manual, sel=5, in_valid pulse, out_ready=1 → out_valid after 2 clk, out_data=8'hA5, out_ch=5.
- Auto mode, in_valid held 18 clk, out_ready=1 → out_ch sequence 0..15, 0, 1. scan_ptr wraps 15→0. out_data matches each channel.
- Backpressure: out_ready=0 with continuous in_valid → exactly 2 accepts, then in_ready=0, with out_data held. Raise out_ready → both items drain in order with no loss or duplicate.
- Reset asserted mid-stream with out_valid=1 → out_valid, out_data, out_ch and scan_ptr all read 0 immediately, asynchronously to clk. in_ready=1 the next cycle.
- MUX_SCAN_MASK_EN, ch_mask=16'h8101, auto → out_ch sequence 0, 8, 15, 0, 8. With ch_mask=0 → in_ready=0 and no outputs.
- Mode switch: auto for 3 accepts (ch 0, 1, 2), then manual with sel=9 → ch 9. Back to auto → ch 3 (scan_ptr held).
